// File: rtl/cmd_fifo.sv
// cmd_fifo: command word FIFO upstream of the buffer executor.
// Assembles 40-bit commands from an opcode byte and a 32-bit payload,
// stores them in a single-clock RAM FIFO and serves the executor's
// fetch interface with a registered read port and local/global counts.
module cmd_fifo #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_hi_data,
  input  logic        in_hi_stb,
  input  logic [31:0] in_lo_data,
  input  logic        in_lo_stb,
  input  logic [31:0] upstream_count,
  input  logic        flush,
  input  logic        clear_overflow,
  input  logic        fifo_read,
  output logic        fifo_empty,
  output logic [39:0] fifo_data,
  output logic [31:0] fifo_local_count,
  output logic [31:0] fifo_global_count,
  output logic        full,
  output logic        overflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [39:0]           r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [7:0]            r_hi;
  logic [39:0]           r_data;
  logic                  r_overflow;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [7:0]            w_hi_next;
  logic [39:0]           w_word;
  logic [32:0]           w_sum;

  // Flags are decoded from the registered count; a full FIFO may still take
  // a push when a pop frees the slot in the same cycle.
  always_comb begin
    w_empty   = (r_count == '0);
    w_full    = (r_count == CNT_FULL);
    w_pop     = fifo_read && !w_empty;
    w_push    = in_lo_stb && (!w_full || w_pop);
    w_drop    = in_lo_stb && !w_push;
    w_hi_next = in_hi_stb ? in_hi_data : r_hi;
    w_word    = {w_hi_next, in_lo_data};
    w_sum     = {1'b0, {(31-ADDR_WIDTH){1'b0}}, r_count} + {1'b0, upstream_count};
  end

  // Storage RAM, intentionally not reset; writes suppressed during reset/flush.
  always_ff @(posedge clk) begin
    if (rst && !flush && w_push) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  // Pointers, count and registered read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_data  <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_data  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_data <= r_mem[r_rptr];
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Opcode register: survives pushes and flushes, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hi <= '0;
    end else if (in_hi_stb) begin
      r_hi <= in_hi_data;
    end
  end

  // Sticky overflow; a drop beats a same-cycle clear, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (!flush && w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  // Output mapping; global count saturates instead of wrapping.
  always_comb begin
    fifo_empty        = w_empty;
    full              = w_full;
    fifo_data         = r_data;
    overflow          = r_overflow;
    fifo_local_count  = {{(31-ADDR_WIDTH){1'b0}}, r_count};
    fifo_global_count = w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
  end

endmodule

// File: tb/tb_cmd_fifo.sv
// tb_cmd_fifo: scoreboard bench for cmd_fifo at depth 8, directed plan
// followed by randomized traffic against a queue-based reference model.
module tb_cmd_fifo;

  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  hi_data;
  logic        hi_stb;
  logic [31:0] lo_data;
  logic        lo_stb;
  logic [31:0] upstream;
  logic        fl;
  logic        clr;
  logic        rd;
  logic        fifo_empty;
  logic [39:0] fifo_data;
  logic [31:0] local_cnt;
  logic [31:0] global_cnt;
  logic        full;
  logic        overflow;

  always #5 clk = ~clk;

  cmd_fifo #(.ADDR_WIDTH(AW)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_hi_data        (hi_data),
    .in_hi_stb         (hi_stb),
    .in_lo_data        (lo_data),
    .in_lo_stb         (lo_stb),
    .upstream_count    (upstream),
    .flush             (fl),
    .clear_overflow    (clr),
    .fifo_read         (rd),
    .fifo_empty        (fifo_empty),
    .fifo_data         (fifo_data),
    .fifo_local_count  (local_cnt),
    .fifo_global_count (global_cnt),
    .full              (full),
    .overflow          (overflow)
  );

  int n_vec  = 0;
  int n_fail = 0;

  logic [39:0] model_q[$];
  logic [39:0] exp_q[$];
  logic [7:0]  m_hi;
  logic [39:0] m_data;
  logic        m_ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b1; hi_stb = 1'b0; lo_stb = 1'b0; fl = 1'b0; clr = 1'b0; rd = 1'b0;
  endtask

  // One clock: model the intended behaviour, advance, then compare state.
  task automatic cycle();
    bit pop, push;
    logic [7:0] hi_n;
    longint gexp;
    hi_n = hi_stb ? hi_data : m_hi;
    pop  = rd && (model_q.size() > 0);
    push = lo_stb && ((model_q.size() < DEPTH) || pop);
    @(posedge clk);
    if (!rst) begin
      model_q.delete(); m_hi = 8'h00; m_data = '0; m_ovf = 1'b0;
    end else begin
      m_hi = hi_n;
      if (fl) begin
        model_q.delete(); m_data = '0;
      end else begin
        if (pop) begin
          m_data = model_q.pop_front();
          exp_q.push_back(m_data);
        end
        if (push) model_q.push_back({hi_n, lo_data});
        if (lo_stb && !push) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
      end
    end
    @(negedge clk);
    gexp = longint'(model_q.size()) + longint'(upstream);
    if (gexp > 64'hFFFF_FFFF) gexp = 64'hFFFF_FFFF;
    check("empty", fifo_empty, model_q.size() == 0);
    check("full", full, model_q.size() == DEPTH);
    check("local_count", local_cnt, model_q.size());
    check("global_count", global_cnt, gexp);
    check("overflow", overflow, m_ovf);
    check("data_hold", fifo_data, m_data);
  endtask

  task automatic do_push(input logic [31:0] d);
    idle_inputs(); lo_stb = 1'b1; lo_data = d; cycle(); idle_inputs();
  endtask

  task automatic do_hi(input logic [7:0] h);
    idle_inputs(); hi_stb = 1'b1; hi_data = h; cycle(); idle_inputs();
  endtask

  task automatic do_read();
    idle_inputs(); rd = 1'b1; cycle(); idle_inputs();
  endtask

  // Monitor: whenever the DUT accepts a read, the next sample must match
  // the oldest expected word from the scoreboard.
  initial begin
    bit took;
    forever begin
      @(posedge clk);
      took = rst && !fl && rd && !fifo_empty;
      @(negedge clk);
      if (took) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_pop: got %0h expected none", fifo_data);
        end else begin
          logic [39:0] e;
          e = exp_q.pop_front();
          if (fifo_data !== e) begin
            n_fail++;
            $display("FAIL sb_data: got %0h expected %0h at %0t", fifo_data, e, $time);
          end
        end
      end
    end
  end

  initial begin
    m_hi = '0; m_data = '0; m_ovf = 1'b0;
    hi_data = '0; lo_data = '0; upstream = 32'd0;
    idle_inputs();
    @(negedge clk);

    // Reset then idle
    rst = 1'b0; cycle(); cycle();
    idle_inputs(); upstream = 32'd5; cycle();
    check("rst_global5", global_cnt, 32'd5);
    check("rst_data0", fifo_data, 40'h0);

    // Packing and order; last push uses a same-cycle hi load
    do_hi(8'h81);
    do_push(32'h0000_0001);
    do_push(32'h0000_0002);
    idle_inputs(); hi_stb = 1'b1; hi_data = 8'h7F; lo_stb = 1'b1; lo_data = 32'hDEAD_BEEF;
    cycle(); idle_inputs();
    do_read(); check("pack0", fifo_data, 40'h81_0000_0001);
    do_read(); check("pack1", fifo_data, 40'h81_0000_0002);
    do_read(); check("pack2", fifo_data, 40'h7F_DEAD_BEEF);
    check("pack_empty", fifo_empty, 1'b1);

    // Fill to full, overflow, push+read while full, clear
    do_hi(8'h10);
    for (int i = 0; i < DEPTH; i++) do_push(32'h100 + i);
    check("full_after8", full, 1'b1);
    do_push(32'h999);
    check("ovf_set", overflow, 1'b1);
    check("cnt_stays8", local_cnt, 32'd8);
    idle_inputs(); rd = 1'b1; lo_stb = 1'b1; lo_data = 32'h108; cycle(); idle_inputs();
    check("full_rw_cnt", local_cnt, 32'd8);
    check("full_rw_word0", fifo_data, 40'h10_0000_0100);
    idle_inputs(); clr = 1'b1; cycle(); idle_inputs();
    check("ovf_clear", overflow, 1'b0);
    for (int i = 0; i < DEPTH; i++) do_read();

    // Wrap-around, incrementing payloads
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) do_push(32'h200 + r * 6 + i);
      for (int i = 0; i < 6; i++) do_read();
    end

    // Read while empty, push+read while empty
    do_read();
    idle_inputs(); rd = 1'b1; lo_stb = 1'b1; lo_data = 32'h333; cycle(); idle_inputs();
    check("pr_empty_cnt", local_cnt, 32'd1);
    do_read(); check("pr_empty_word", fifo_data, 40'h10_0000_0333);

    // Flush with count 5 and a same-cycle push; overflow preserved
    for (int i = 0; i < DEPTH + 1; i++) do_push(32'h400 + i);
    for (int i = 0; i < 3; i++) do_read();
    idle_inputs(); fl = 1'b1; lo_stb = 1'b1; lo_data = 32'h555; rd = 1'b1; cycle(); idle_inputs();
    check("flush_cnt", local_cnt, 32'd0);
    check("flush_ovf_kept", overflow, 1'b1);
    idle_inputs(); clr = 1'b1; cycle(); idle_inputs();

    // Global count saturation
    for (int i = 0; i < 3; i++) do_push(32'h600 + i);
    upstream = 32'hFFFF_FFFE; cycle();
    check("global_sat", global_cnt, 32'hFFFF_FFFF);
    upstream = 32'd7;

    // Reset mid-stream
    do_push(32'h603);
    idle_inputs(); rst = 1'b0; cycle(); idle_inputs();
    do_push(32'h42);
    do_read(); check("post_rst_word", fifo_data, 40'h00_0000_0042);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      hi_stb  = ($urandom_range(0, 7) == 0);
      hi_data = 8'($urandom);
      lo_stb  = ($urandom_range(0, 99) < ((n / 300) % 2 ? 70 : 40));
      lo_data = $urandom;
      rd      = ($urandom_range(0, 99) < ((n / 300) % 2 ? 40 : 65));
      fl      = ($urandom_range(0, 79) == 0);
      clr     = !fl && ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 9) == 0)
        upstream = ($urandom_range(0, 1) != 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
      cycle();
    end

    idle_inputs();
    cycle();
    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_fifo.md
# cmd_fifo

Command FIFO that sits directly upstream of the buffer executor. It assembles 40-bit command words from two host register strobes: an 8-bit opcode byte and a 32-bit payload. It stores them in a single-clock synchronous FIFO and presents them through the executor's fetch interface: `fifo_empty`, registered `fifo_data`, `fifo_read`, and local/global counts. It also reports full/overflow status and supports a synchronous flush.

## Interface
- `ADDR_WIDTH`, default 9: FIFO depth is 2^ADDR_WIDTH words (512).
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `in_hi_data`  in  8  opcode byte, becomes bits [39:32] of pushed words.
- `in_hi_stb`  in  1  loads `in_hi_data` into the hi register.
- `in_lo_data`  in  32  payload, becomes bits [31:0].
- `in_lo_stb`  in  1  pushes {hi register, `in_lo_data`}.
- `upstream_count`  in  32  words held in levels above this FIFO (DMA/host buffers).
- `flush`  in  1  discard all stored words.
- `clear_overflow`  in  1  clears the sticky `overflow` flag.
- `fifo_read`  in  1  pop request from the executor.
- `fifo_empty`  out  1  no stored words.
- `fifo_data`  out  40  word popped by the previous cycle's accepted read.
- `fifo_local_count`  out  32  stored words, zero-extended.
- `fifo_global_count`  out  32  local + upstream, saturating.
- `full`  out  1  stored words == 2^ADDR_WIDTH.
- `overflow`  out  1  sticky: a push was dropped.

## Operation
- Storage: RAM of 2^ADDR_WIDTH × 40 bits, not reset.
  - Write/read pointers are ADDR_WIDTH bits and wrap modulo depth.
  - The count register is ADDR_WIDTH+1 bits.
- Hi register (8 bits):
  - Loaded on `in_hi_stb`.
  - Persists across pushes, so repeated payloads reuse the same opcode.
  - If `in_hi_stb` and `in_lo_stb` are asserted in the same cycle, the pushed word uses the new `in_hi_data`.
- Push accepted = `in_lo_stb` && (!full || pop accepted this cycle). Otherwise the word is dropped and `overflow` is set.
- Pop accepted = `fifo_read` && !`fifo_empty`.
  - A read while empty is ignored; there is no fall-through of a same-cycle push.
  - `fifo_data` holds its value when no pop is accepted.
- Count update:
  - +1 on push only, −1 on pop only.
  - Unchanged on both or neither.
- Flags:
  - `fifo_empty` = (count == 0).
  - `full` = (count == 2^ADDR_WIDTH).
  - Both are decoded from the count register, i.e. registered state.
- `fifo_local_count` = count, zero-extended to 32 bits.
- `fifo_global_count` = count + `upstream_count`, combinational, computed with 33-bit arithmetic and saturated at 0xFFFFFFFF.
- Flush:
  - Pointers and count are set to 0 and `fifo_data` is set to 0.
  - Same-cycle push and pop are discarded; a discarded push does not set `overflow`.
  - The hi register and `overflow` are kept.
- Overflow:
  - `clear_overflow` clears it.
  - If a drop and `clear_overflow` occur in the same cycle, the set wins.
- Priority, highest first: reset, flush, push/pop.

## Timing
- Reset (`rst`=0 at an edge) clears:
  - pointers, count, hi register;
  - `fifo_data`=0, `overflow`=0.
  - Resulting outputs: `fifo_empty`=1, `full`=0, `fifo_local_count`=0, `fifo_global_count`=`upstream_count`.
- Push latency: a word pushed at edge N is visible in count and `fifo_empty` after edge N, so it is poppable from cycle N+1.
- Read latency: 1 cycle. `fifo_read` sampled at edge N yields the word on `fifo_data` after edge N, valid through cycle N+1. This matches the executor's fetch/latch sequence.
- Back-to-back reads every cycle are supported. The executor's drain loop reads until `fifo_empty`, and `fifo_empty` reflects each pop after the same edge.
- Simultaneous push and pop when full: both accepted, `full` stays 1.
- Simultaneous push and read when empty: push accepted, read ignored, count becomes 1.
- Pointer wrap from 2^ADDR_WIDTH−1 to 0 is seamless; order is preserved across the wrap.
- Reset mid-stream discards all contents; the first subsequent push is read back first.

## Test plan
- Reset then idle:
  - Expect `fifo_empty`=1, counts 0, `fifo_data`=0.
  - With `upstream_count`=5, expect `fifo_global_count`=5.
- Packing and order:
  - Load hi=0x81, push 0x00000001 and 0x00000002; load hi=0x7F, push 0xDEADBEEF.
  - Three reads, one per cycle, return 0x8100000001, 0x8100000002, 0x7FDEADBEEF, each one cycle after its read.
  - After the last read, `fifo_empty`=1.
- Fill to full (ADDR_WIDTH=3, 8 words):
  - Expect `full`=1 after the 8th push.
  - A 9th push sets `overflow` and count stays 8.
  - A push+read in the same cycle while full keeps count at 8 and returns word 0.
  - `clear_overflow` clears the flag.
- Wrap-around (depth 8):
  - Push 6, pop 6, push 6, pop 6 with incrementing payloads.
  - Data order is correct across the pointer wrap.
- Boundary events:
  - Read while empty: no data change.
  - Push+read while empty: count=1, word readable next cycle.
  - Flush with count=5 and a same-cycle push: count=0, `fifo_empty`=1, `overflow` unchanged.
- Global count saturation: count=3 with `upstream_count`=0xFFFFFFFE gives `fifo_global_count`=0xFFFFFFFF.
- Reset mid-stream: count=4 then reset; then push 0x42 → first read returns it with hi=0x00.
